// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: buffers {a, b, op} commands in a small FIFO, presents the head
// to an external combinational ALU, and captures the ALU result into a
// registered output slot with its own valid/ready handshake.
module alu_cmd_issue #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [7:0]    cmd_a_i,
  input  logic [7:0]    cmd_b_i,
  input  logic [2:0]    cmd_op_i,
  output logic [7:0]    alu_a_o,
  output logic [7:0]    alu_b_o,
  output logic [2:0]    alu_op_o,
  input  logic [7:0]    alu_res_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [7:0]    res_data_o,
  output logic [2:0]    res_op_o,
  output logic [CW-1:0] count_o
);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          not_empty, slot_free, push, issue;

  // Ready depends only on registered occupancy, so a full FIFO refuses a push
  // even when the head is leaving in the same cycle.
  assign not_empty   = (count_o != '0);
  assign cmd_ready_o = (count_o != CW'(DEPTH));
  assign push        = cmd_valid_i & cmd_ready_o;
  assign slot_free   = ~res_valid_o | res_ready_i;
  assign issue       = not_empty & slot_free;

  // Head is read straight from storage; zeroed when empty so the ALU sees a
  // quiet, deterministic input instead of stale entries.
  assign head     = mem[rd_ptr];
  assign alu_a_o  = not_empty ? head.a  : '0;
  assign alu_b_o  = not_empty ? head.b  : '0;
  assign alu_op_o = not_empty ? head.op : '0;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: cmd_a_i, b: cmd_b_i, op: cmd_op_i};
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      count_o <= count_o + CW'(push) - CW'(issue);
    end
  end

  // Result slot: load on issue, otherwise drain on consumer accept; data and
  // opcode hold whenever no new result is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_op_o    <= '0;
    end else if (issue) begin
      res_valid_o <= 1'b1;
      res_data_o  <= alu_res_i;
      res_op_o    <= alu_op_o;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: a stand-in combinational ALU, a queue scoreboard
// filled on accepted commands and drained by a monitor on accepted results.
module tb_alu_cmd_issue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 0;
  logic          reset = 1;
  logic          cmd_valid = 0;
  logic          cmd_ready;
  logic [7:0]    cmd_a = 0, cmd_b = 0;
  logic [2:0]    cmd_op = 0;
  logic [7:0]    alu_a, alu_b, alu_res;
  logic [2:0]    alu_op;
  logic          res_valid;
  logic          res_ready = 0;
  logic [7:0]    res_data;
  logic [2:0]    res_op;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;
  int accepted = 0;
  logic [10:0] sbq [$];   // {op, result} in acceptance order

  always #5 clk = ~clk;

  alu_cmd_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_res_i(alu_res),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_op_o(res_op),
    .count_o(count)
  );

  // Stand-in 8-bit ALU; op 111 is an equality compare.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a >> 1;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  always_comb alu_res = alu_f(alu_a, alu_b, alu_op);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: inputs settle at posedge+1, so the negedge view is
  // exactly what the next posedge will act on.
  always @(negedge clk) begin
    if (!reset) begin
      if (res_valid && res_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_result", {res_op, res_data}, 0);
        end else begin
          check("result", {res_op, res_data}, sbq.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) begin
        sbq.push_back({cmd_op, alu_f(cmd_a, cmd_b, cmd_op)});
        accepted++;
      end
    end
  end

  // Hold a command until accepted (bounded); leaves cmd_valid asserted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit ok = 0;
    cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_op = op;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    cmd_valid = 0; res_ready = 1;
    while ((sbq.size() != 0 || res_valid) && t < budget) begin
      @(posedge clk); #1; t++;
    end
    check("drain_empty", sbq.size(), 0);
    check("drain_valid", res_valid, 0);
    check("drain_count", count, 0);
  endtask

  initial begin
    logic [7:0] held;
    bit stable;

    // Reset state.
    #1;
    check("rst_count", count, 0);
    check("rst_valid", res_valid, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    @(posedge clk); #1; reset = 0;

    // Single command latency: accepted at edge N, result valid after edge N+1.
    res_ready = 1;
    send(8'h12, 8'h34, 3'b000);
    cmd_valid = 0;
    check("lat_count1", count, 1);
    check("lat_not_yet", res_valid, 0);
    check("head_a", alu_a, 8'h12);
    @(posedge clk); #1;
    check("lat_valid", res_valid, 1);
    check("lat_data", res_data, 8'h46);
    check("lat_count0", count, 0);
    @(posedge clk); #1;

    // Boundary arithmetic vectors.
    send(8'h00, 8'h01, 3'b001);
    send(8'h5A, 8'h5A, 3'b111);
    send(8'h5A, 8'h5B, 3'b111);
    drain(20);

    // Capacity with consumer stalled: 6 attempts, 5 accepted.
    res_ready = 0; accepted = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1; cmd_a = 8'(8'h10 + i); cmd_b = 8'h03; cmd_op = 3'(i);
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    check("full_accepted", accepted, 5);
    check("full_count", count, 4);
    check("full_ready", cmd_ready, 0);
    check("full_valid", res_valid, 1);
    check("full_data", res_data, 8'h13);
    held = res_data; stable = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_data !== held || res_valid !== 1'b1 || count !== CW'(4)) stable = 0;
    end
    check("full_stable", stable, 1);

    // Drain from full: five consecutive results, then empty.
    @(posedge clk); #1; res_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("drain_consec", res_valid, 1);
      check("ready_vs_count", cmd_ready, (count != CW'(4)));
    end
    @(negedge clk);
    check("drain_done_valid", res_valid, 0);
    check("drain_done_count", count, 0);
    @(posedge clk); #1;

    // Back-to-back stream, pointers wrap twice.
    for (int i = 0; i < 10; i++) send(8'(i), 8'h01, 3'(i));
    cmd_valid = 0;
    drain(20);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      if (!(cmd_valid && !cmd_ready) || $urandom_range(0, 3) == 0) begin
        cmd_valid = ($urandom_range(0, 9) < 6);
        cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 3'($urandom);
      end
      res_ready = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    drain(40);

    // Asynchronous reset with 3 buffered and a pending result.
    res_ready = 0;
    for (int i = 0; i < 4; i++) send(8'(8'h20 + i), 8'h02, 3'd0);
    cmd_valid = 0;
    check("pre_rst_count", count, 3);
    check("pre_rst_valid", res_valid, 1);
    #2 reset = 1;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", res_valid, 0);
    check("arst_res", {res_op, res_data}, 0);
    check("arst_alu", {alu_a, alu_b, alu_op}, 0);
    @(negedge clk); @(posedge clk); #1;
    sbq.delete();
    reset = 0;
    res_ready = 1;
    send(8'h01, 8'h01, 3'b000);
    cmd_valid = 0;
    @(posedge clk); #1;
    check("post_rst_valid", res_valid, 1);
    check("post_rst_data", res_data, 8'h02);
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
